ucore_output_channels: RTL and testbench

UCORE_OUTPUT_CHANNELS -- requirements
Module: ucore_output_channels

---
 rtl/ucore_pkg.sv | 7 +
 rtl/ucore_eager_fork.sv | 46 ++++
 rtl/ucore_output_channels.sv | 94 +++++++++
 tb/tb_ucore_output_channels.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ucore_pkg.sv
// Shared constants for the ucore output path.
//   UCORE_DATA_W   : default token width
//   UCORE_MAX_DEST : largest number of NoC destinations one output may feed
package ucore_pkg;
  localparam int UCORE_DATA_W   = 32;
  localparam int UCORE_MAX_DEST = 8;
endpackage

// File: rtl/ucore_eager_fork.sv
// Eager fork: tracks which destinations have already taken the head token
// so each one handshakes independently and is never offered it twice.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   valid_i      : head token present (buffer non-empty)
//   dest_en_i    : destination enable mask
//   ready_i      : per-destination ready from the NoC
//   valid_o      : per-destination valid to the NoC
//   pop_o        : head may be dequeued this cycle
module ucore_eager_fork
  import ucore_pkg::*;
#(
  parameter int N_DEST = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [N_DEST-1:0] dest_en_i,
  input  logic [N_DEST-1:0] ready_i,
  output logic [N_DEST-1:0] valid_o,
  output logic              pop_o
);

  if (N_DEST < 1 || N_DEST > UCORE_MAX_DEST) begin : g_dest_range
    $error("ucore_eager_fork: N_DEST out of range");
  end

  logic [N_DEST-1:0] sent_q, sent_d;
  logic [N_DEST-1:0] hs;
  logic [N_DEST-1:0] done;

  always_comb begin
    valid_o = {N_DEST{valid_i}} & dest_en_i & ~sent_q;
    hs      = valid_o & ready_i;
    // A disabled destination counts as served, so dropping its enable
    // while the head is pending cannot stall the queue.
    done    = ~dest_en_i | sent_q | hs;
    pop_o   = valid_i & (&done);
    sent_d  = pop_o ? '0 : (sent_q | hs);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sent_q <= '0;
    else       sent_q <= sent_d;
  end

endmodule

// File: rtl/ucore_output_channels.sv
// Output buffer of a ucore feeding up to N_DEST NoC destinations through an
// eager fork. Tokens are queued in a small circular buffer; the head is
// broadcast on noc_out and dequeued once every enabled destination took it.
//   clk, rst        : clock, asynchronous active-high reset
//   dest_en         : destination enable mask (quasi-static)
//   ucore_ivalid/in : token offered by the ucore datapath
//   ucore_oready    : buffer can accept a token
//   noc_ovalid      : per-destination valid
//   noc_out         : head token, shared by all destinations
//   noc_iready      : per-destination ready
//   occupancy       : entries currently held
module ucore_output_channels
  import ucore_pkg::*;
#(
  parameter int DATA_WIDTH          = UCORE_DATA_W,
  parameter int N_DEST              = 2,
  parameter int OUTPUT_BUFFER_DEPTH = 2
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [N_DEST-1:0]                        dest_en,
  input  logic                                     ucore_ivalid,
  input  logic [DATA_WIDTH-1:0]                    ucore_in,
  output logic                                     ucore_oready,
  output logic [N_DEST-1:0]                        noc_ovalid,
  output logic [DATA_WIDTH-1:0]                    noc_out,
  input  logic [N_DEST-1:0]                        noc_iready,
  output logic [$clog2(OUTPUT_BUFFER_DEPTH+1)-1:0] occupancy
);

  localparam int AW = $clog2(OUTPUT_BUFFER_DEPTH);
  localparam int OW = $clog2(OUTPUT_BUFFER_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [OUTPUT_BUFFER_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]         occ_q, occ_d;
  logic                  live_q;
  logic                  push, pop, not_empty;

  assign not_empty = (occ_q != '0);
  // live_q holds ready low during reset and until the first edge after it.
  // Ready looks only at occupancy, never at this cycle's dequeue.
  assign ucore_oready = live_q && (occ_q != OW'(OUTPUT_BUFFER_DEPTH));
  assign push         = ucore_ivalid && ucore_oready;
  assign occupancy    = occ_q;
  assign noc_out      = mem_q[rd_ptr_q];

  ucore_eager_fork #(
    .N_DEST (N_DEST)
  ) u_fork (
    .clk_i     (clk),
    .rst_i     (rst),
    .valid_i   (not_empty),
    .dest_en_i (dest_en),
    .ready_i   (noc_iready),
    .valid_o   (noc_ovalid),
    .pop_o     (pop)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) wr_ptr_d = (wr_ptr_q == AW'(OUTPUT_BUFFER_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == AW'(OUTPUT_BUFFER_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      live_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      live_q   <= 1'b1;
    end
  end

  // Token storage carries no reset; stale entries are unreachable once the
  // pointers and occupancy are cleared.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ucore_in;
  end

endmodule

// File: tb/tb_ucore_output_channels.sv
module tb_ucore_output_channels;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  dest_en;
  logic        ucore_ivalid;
  logic [31:0] ucore_in;
  logic        ucore_oready;
  logic [1:0]  noc_ovalid;
  logic [31:0] noc_out;
  logic [1:0]  noc_iready;
  logic [1:0]  occupancy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ucore_output_channels #(
    .DATA_WIDTH          (32),
    .N_DEST              (2),
    .OUTPUT_BUFFER_DEPTH (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .dest_en      (dest_en),
    .ucore_ivalid (ucore_ivalid),
    .ucore_in     (ucore_in),
    .ucore_oready (ucore_oready),
    .noc_ovalid   (noc_ovalid),
    .noc_out      (noc_out),
    .noc_iready   (noc_iready),
    .occupancy    (occupancy)
  );

  typedef struct {
    logic [1:0]  en;
    logic        iv;
    logic [31:0] din;
    logic [1:0]  rdy;
    logic [1:0]  e_ov;
    logic        e_ordy;
    logic [1:0]  e_occ;
    logic        chk_out;
    logic [31:0] e_out;
  } vec_t;

  vec_t vec[64];
  int   nvec = 0;

  task automatic add(input logic [1:0] en, input logic iv, input logic [31:0] din,
                     input logic [1:0] rdy, input logic [1:0] e_ov, input logic e_ordy,
                     input logic [1:0] e_occ, input logic chk_out, input logic [31:0] e_out);
    vec[nvec] = '{en, iv, din, rdy, e_ov, e_ordy, e_occ, chk_out, e_out};
    nvec++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] en, input logic iv, input logic [31:0] din,
                       input logic [1:0] rdy);
    dest_en = en; ucore_ivalid = iv; ucore_in = din; noc_iready = rdy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // columns: en iv din rdy | ovalid oready occ chk_out out
    // back-to-back A,B,C to both destinations
    add(2'b11, 1, 32'hA,  2'b11, 2'b00, 1, 2'd0, 0, 32'h0);
    add(2'b11, 1, 32'hB,  2'b11, 2'b11, 1, 2'd1, 1, 32'hA);
    add(2'b11, 1, 32'hC,  2'b11, 2'b11, 1, 2'd1, 1, 32'hB);
    add(2'b11, 0, 32'h0,  2'b11, 2'b11, 1, 2'd1, 1, 32'hC);
    add(2'b11, 0, 32'h0,  2'b11, 2'b00, 1, 2'd0, 0, 32'h0);
    // dest 1 stalls three cycles on 0x5, dest 0 not re-offered
    add(2'b11, 1, 32'h5,  2'b11, 2'b00, 1, 2'd0, 0, 32'h0);
    add(2'b11, 0, 32'h0,  2'b01, 2'b11, 1, 2'd1, 1, 32'h5);
    add(2'b11, 0, 32'h0,  2'b01, 2'b10, 1, 2'd1, 1, 32'h5);
    add(2'b11, 0, 32'h0,  2'b01, 2'b10, 1, 2'd1, 1, 32'h5);
    add(2'b11, 0, 32'h0,  2'b01, 2'b10, 1, 2'd1, 1, 32'h5);
    add(2'b11, 0, 32'h0,  2'b11, 2'b10, 1, 2'd1, 1, 32'h5);
    add(2'b11, 0, 32'h0,  2'b11, 2'b00, 1, 2'd0, 0, 32'h0);
    // fill to depth, third token held off until first dequeue
    add(2'b11, 1, 32'h11, 2'b00, 2'b00, 1, 2'd0, 0, 32'h0);
    add(2'b11, 1, 32'h22, 2'b00, 2'b11, 1, 2'd1, 1, 32'h11);
    add(2'b11, 1, 32'h33, 2'b00, 2'b11, 0, 2'd2, 1, 32'h11);
    add(2'b11, 1, 32'h33, 2'b11, 2'b11, 0, 2'd2, 1, 32'h11);
    add(2'b11, 1, 32'h33, 2'b00, 2'b11, 1, 2'd1, 1, 32'h22);
    // full buffer, pop and push around the boundary, order preserved
    add(2'b11, 0, 32'h0,  2'b00, 2'b11, 0, 2'd2, 1, 32'h22);
    add(2'b11, 1, 32'h44, 2'b11, 2'b11, 0, 2'd2, 1, 32'h22);
    add(2'b11, 1, 32'h44, 2'b11, 2'b11, 1, 2'd1, 1, 32'h33);
    add(2'b11, 1, 32'h55, 2'b00, 2'b11, 1, 2'd1, 1, 32'h44);
    add(2'b11, 0, 32'h0,  2'b11, 2'b11, 0, 2'd2, 1, 32'h44);
    add(2'b11, 0, 32'h0,  2'b11, 2'b11, 1, 2'd1, 1, 32'h55);
    add(2'b11, 0, 32'h0,  2'b11, 2'b00, 1, 2'd0, 0, 32'h0);
    // all destinations disabled: head discarded each cycle
    add(2'b11, 1, 32'h66, 2'b00, 2'b00, 1, 2'd0, 0, 32'h0);
    add(2'b11, 1, 32'h77, 2'b00, 2'b11, 1, 2'd1, 1, 32'h66);
    add(2'b00, 0, 32'h0,  2'b00, 2'b00, 0, 2'd2, 0, 32'h0);
    add(2'b00, 0, 32'h0,  2'b00, 2'b00, 1, 2'd1, 0, 32'h0);
    add(2'b00, 0, 32'h0,  2'b00, 2'b00, 1, 2'd0, 0, 32'h0);
    // dest 1 disabled while its entry is pending counts as accepted
    add(2'b11, 1, 32'h88, 2'b00, 2'b00, 1, 2'd0, 0, 32'h0);
    add(2'b11, 0, 32'h0,  2'b01, 2'b11, 1, 2'd1, 1, 32'h88);
    add(2'b01, 0, 32'h0,  2'b00, 2'b00, 1, 2'd1, 0, 32'h0);
    add(2'b11, 0, 32'h0,  2'b00, 2'b00, 1, 2'd0, 0, 32'h0);

    // reset state, with traffic offered
    rst = 1'b1;
    drive(2'b11, 1, 32'hDEAD, 2'b11);
    #2;
    chk("rst_ovalid", 32'(noc_ovalid), 32'h0);
    chk("rst_oready", 32'(ucore_oready), 32'h0);
    chk("rst_occ", 32'(occupancy), 32'h0);
    next_cycle();
    next_cycle();
    drive(2'b11, 0, 32'h0, 2'b00);
    rst = 1'b0;
    next_cycle();
    chk("post_rst_oready", 32'(ucore_oready), 32'h1);

    for (int i = 0; i < nvec; i++) begin
      drive(vec[i].en, vec[i].iv, vec[i].din, vec[i].rdy);
      @(negedge clk);
      chk($sformatf("v%0d_ovalid", i), 32'(noc_ovalid), 32'(vec[i].e_ov));
      chk($sformatf("v%0d_oready", i), 32'(ucore_oready), 32'(vec[i].e_ordy));
      chk($sformatf("v%0d_occ", i), 32'(occupancy), 32'(vec[i].e_occ));
      if (vec[i].chk_out) chk($sformatf("v%0d_out", i), noc_out, vec[i].e_out);
      next_cycle();
    end

    // reset mid-stream with two entries held and dest 0 already served
    drive(2'b11, 1, 32'h91, 2'b00);
    next_cycle();
    drive(2'b11, 1, 32'h92, 2'b00);
    next_cycle();
    drive(2'b11, 0, 32'h0, 2'b01);
    @(negedge clk);
    chk("mid_pre_occ", 32'(occupancy), 32'h2);
    next_cycle();
    drive(2'b11, 0, 32'h0, 2'b00);
    #1;
    chk("mid_sent_ovalid", 32'(noc_ovalid), 32'h2);
    rst = 1'b1;
    #1;
    chk("mid_rst_ovalid", 32'(noc_ovalid), 32'h0);
    chk("mid_rst_occ", 32'(occupancy), 32'h0);
    chk("mid_rst_oready", 32'(ucore_oready), 32'h0);
    next_cycle();
    rst = 1'b0;
    next_cycle();
    drive(2'b11, 1, 32'hA5, 2'b00);
    @(negedge clk);
    chk("new_oready", 32'(ucore_oready), 32'h1);
    next_cycle();
    drive(2'b11, 0, 32'h0, 2'b01);
    @(negedge clk);
    chk("new_ovalid", 32'(noc_ovalid), 32'h3);
    chk("new_out", noc_out, 32'hA5);
    chk("new_occ", 32'(occupancy), 32'h1);
    next_cycle();
    drive(2'b11, 0, 32'h0, 2'b10);
    @(negedge clk);
    chk("new_d1_ovalid", 32'(noc_ovalid), 32'h2);
    chk("new_d1_out", noc_out, 32'hA5);
    next_cycle();
    drive(2'b11, 0, 32'h0, 2'b00);
    @(negedge clk);
    chk("new_done_occ", 32'(occupancy), 32'h0);
    chk("new_done_ovalid", 32'(noc_ovalid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
